// File: rtl/reg_file_flags_pkg.sv
// Shared constants for the register file and the ALU: zero-register address,
// flag bit ordering inside FR and default datapath widths.
package reg_file_flags_pkg;

  localparam int unsigned REG_ZERO       = 0;
  localparam int unsigned FR_W           = 4;
  localparam int unsigned FR_ZF          = 3;
  localparam int unsigned FR_CF          = 2;
  localparam int unsigned FR_OF          = 1;
  localparam int unsigned FR_SF          = 0;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned WR_CNT_W       = 8;

endpackage

// File: rtl/reg_file_flags_flag_reg.sv
// Enabled flag register with asynchronous active-low clear; also usable for the
// ALU's own flag capture.
module flag_reg
  import reg_file_flags_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [FR_W-1:0] d_i,
  output logic [FR_W-1:0] q_o
);

  logic [FR_W-1:0] flags_q;
  logic [FR_W-1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (en_i) begin
      flags_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign q_o = flags_q;

endmodule

// File: rtl/reg_file_flags.sv
// Two-read/one-write register file with hardwired-zero r0, saturating write
// counter and a 4-bit flag register fed by the ALU status bits.
module reg_file_flags
  import reg_file_flags_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   R_Addr_A,
  input  logic [ADDR_W-1:0]   R_Addr_B,
  input  logic [ADDR_W-1:0]   W_Addr,
  input  logic [DATA_W-1:0]   W_Data,
  input  logic                Write_Reg,
  input  logic                Flag_En,
  input  logic                ZF_in,
  input  logic                CF_in,
  input  logic                OF_in,
  input  logic                SF_in,
  output logic [DATA_W-1:0]   R_Data_A,
  output logic [DATA_W-1:0]   R_Data_B,
  output logic [FR_W-1:0]     FR,
  output logic [WR_CNT_W-1:0] Wr_Cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   regs_q [NumRegs];
  logic [WR_CNT_W-1:0] wr_cnt_q;
  logic [WR_CNT_W-1:0] wr_cnt_d;
  logic                wr_en;
  logic [FR_W-1:0]     flags_in;

  // Writes to r0 are dropped entirely, including the counter update.
  assign wr_en = Write_Reg && (W_Addr != ZeroAddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[W_Addr] <= W_Data;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_en && (wr_cnt_q != {WR_CNT_W{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign Wr_Cnt = wr_cnt_q;

  // No write bypass: reads see the array contents before the edge.
  assign R_Data_A = (R_Addr_A == ZeroAddr) ? '0 : regs_q[R_Addr_A];
  assign R_Data_B = (R_Addr_B == ZeroAddr) ? '0 : regs_q[R_Addr_B];

  always_comb begin
    flags_in        = '0;
    flags_in[FR_ZF] = ZF_in;
    flags_in[FR_CF] = CF_in;
    flags_in[FR_OF] = OF_in;
    flags_in[FR_SF] = SF_in;
  end

  flag_reg u_flag_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (Flag_En),
    .d_i  (flags_in),
    .q_o  (FR)
  );

endmodule
